// File: rtl/tdm_demux_1to8.sv
// Receiving end of an 8-slot serial TDM link: locks onto a sync-marked slot-0 bit,
// demultiplexes one accepted bit per slot (LSB first) and publishes each complete frame.
module tdm_demux_1to8 #(
  parameter int unsigned GAP_MAX = 15
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       d_in,
  input  logic       vld_in,
  input  logic       sync_in,
  output logic [7:0] y_out,
  output logic       y_vld_out,
  output logic [2:0] sel_out,
  output logic       lock_out,
  output logic       err_out
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [7:0] GAP_LIMIT = 8'(GAP_MAX);

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] y_q, y_d;
  logic       y_vld_q, y_vld_d;
  logic       err_q, err_d;
  logic [7:0] gap_inc;

  assign gap_inc = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    gap_d    = gap_q;
    y_d      = y_q;
    y_vld_d  = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_in && sync_in) begin
          shadow_d = {7'b0, d_in};
          sel_d    = 3'd1;
          gap_d    = 8'd0;
          state_d  = LOCK;
        end
      end

      LOCK: begin
        if (vld_in) begin
          gap_d = 8'd0;
          if (sync_in && (sel_q != 3'd0)) begin
            // Misplaced sync: drop the partial frame and restart it on this bit.
            err_d    = 1'b1;
            shadow_d = {7'b0, d_in};
            sel_d    = 3'd1;
          end else begin
            shadow_d[sel_q] = d_in;
            sel_d           = sel_q + 3'd1;
            if (sel_q == 3'd7) begin
              y_d     = {d_in, shadow_q[6:0]};
              y_vld_d = 1'b1;
            end
          end
        end else if (sel_q != 3'd0) begin
          gap_d = gap_inc;
          if (gap_inc >= GAP_LIMIT) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            sel_d    = 3'd0;
            shadow_d = 8'd0;
            gap_d    = 8'd0;
          end
        end else begin
          // Idle between frames is not a gap; only mid-frame silence times out.
          gap_d = 8'd0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
    if (rst_in) begin
      state_q  <= IDLE;
      shadow_q <= 8'd0;
      sel_q    <= 3'd0;
      gap_q    <= 8'd0;
      y_q      <= 8'd0;
      y_vld_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      gap_q    <= gap_d;
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
      err_q    <= err_d;
    end
  end

  assign y_out     = y_q;
  assign y_vld_out = y_vld_q;
  assign sel_out   = sel_q;
  assign lock_out  = (state_q == LOCK);
  assign err_out   = err_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed bench for tdm_demux_1to8: reset, framing, back-to-back frames, framing
// errors, gap timeout boundaries and mid-frame reset, with hand-computed expectations.
module tb_tdm_demux_1to8;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       d_in;
  logic       vld_in;
  logic       sync_in;
  logic [7:0] y_out;
  logic       y_vld_out;
  logic [2:0] sel_out;
  logic       lock_out;
  logic       err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  tdm_demux_1to8 #(.GAP_MAX(15)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .d_in     (d_in),
    .vld_in   (vld_in),
    .sync_in  (sync_in),
    .y_out    (y_out),
    .y_vld_out(y_vld_out),
    .sel_out  (sel_out),
    .lock_out (lock_out),
    .err_out  (err_out)
  );

  // Status word layout: {y_vld, err, lock, sel[2:0]}.
  function automatic logic [5:0] status();
    return {y_vld_out, err_out, lock_out, sel_out};
  endfunction

  // Apply inputs at a negedge, return at the next negedge with outputs settled.
  task automatic step(input logic v, input logic d, input logic s);
    vld_in  = v;
    d_in    = d;
    sync_in = s;
    @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [7:0] b, input int first, input int last,
                           input logic sync_first);
    for (int k = first; k <= last; k++) step(1'b1, b[k], sync_first && (k == first));
  endtask

  task automatic test_reset();
    logic [5:0] exp_s;
    rst_in = 1'b1;
    exp_s  = 6'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if ({status(), y_out} !== {exp_s, 8'h00}) begin
        errors++;
        $display("FAIL reset[%0d]: status=%b y=%h, expected status=%b y=%h",
                 i, status(), y_out, exp_s, 8'h00);
      end
    end
    rst_in = 1'b0;
  endtask

  task automatic test_frame_a5();
    logic [7:0] b;
    logic [5:0] exp_s;
    b = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, b[k], k == 0);
      exp_s = {(k == 7), 1'b0, 1'b1, 3'(k + 1)};
      checks++;
      if (status() !== exp_s || (k == 7 && y_out !== 8'hA5)) begin
        errors++;
        $display("FAIL frame_a5 bit%0d: status=%b y=%h, expected status=%b y=%h",
                 k, status(), y_out, exp_s, 8'hA5);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({status(), y_out} !== {6'b001000, 8'hA5}) begin
      errors++;
      $display("FAIL frame_a5 hold: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b001000, 8'hA5);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] frames [2];
    logic [7:0] cur;
    logic [5:0] exp_s;
    frames[0] = 8'h3C;
    frames[1] = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      cur = frames[i / 8];
      step(1'b1, cur[i % 8], i == 0);
      exp_s = {(i % 8 == 7), 1'b0, 1'b1, 3'(i + 1)};
      checks++;
      if (status() !== exp_s || (i % 8 == 7 && y_out !== cur)) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: status=%b y=%h, expected status=%b y=%h",
                 i, status(), y_out, exp_s, cur);
      end
    end
  endtask

  task automatic test_idle_ignore();
    rst_in = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({status(), y_out} !== {6'b0, 8'h00}) begin
        errors++;
        $display("FAIL idle_ignore[%0d]: status=%b y=%h, expected status=%b y=%h",
                 i, status(), y_out, 6'b0, 8'h00);
      end
    end
  endtask

  task automatic test_framing_error();
    logic [5:0] exp_s;
    send_bits(8'hA5, 0, 7, 1'b1);
    send_bits(8'h07, 0, 2, 1'b1);
    checks++;
    if ({status(), y_out} !== {6'b001011, 8'hA5}) begin
      errors++;
      $display("FAIL ferr_pre: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b001011, 8'hA5);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if ({status(), y_out} !== {6'b011001, 8'hA5}) begin
      errors++;
      $display("FAIL ferr_pulse: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b011001, 8'hA5);
    end
    for (int k = 1; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      exp_s = {(k == 7), 1'b0, 1'b1, 3'(k + 1)};
      checks++;
      if (status() !== exp_s || y_out !== ((k == 7) ? 8'h01 : 8'hA5)) begin
        errors++;
        $display("FAIL ferr_refill slot%0d: status=%b y=%h, expected status=%b y=%h",
                 k, status(), y_out, exp_s, (k == 7) ? 8'h01 : 8'hA5);
      end
    end
  endtask

  task automatic test_gap();
    // Idle at slot 0 never times out.
    for (int g = 0; g < 20; g++) step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({status(), y_out} !== {6'b001000, 8'h01}) begin
      errors++;
      $display("FAIL gap_slot0: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b001000, 8'h01);
    end
    // 15-cycle mid-frame gap aborts on the 15th idle cycle.
    send_bits(8'h5A, 0, 3, 1'b1);
    for (int g = 1; g <= 14; g++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (status() !== 6'b001100) begin
        errors++;
        $display("FAIL gap15 idle%0d: status=%b, expected status=%b",
                 g, status(), 6'b001100);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({status(), y_out} !== {6'b010000, 8'h01}) begin
      errors++;
      $display("FAIL gap15_timeout: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b010000, 8'h01);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({status(), y_out} !== {6'b000000, 8'h01}) begin
      errors++;
      $display("FAIL gap15_after: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b000000, 8'h01);
    end
    // 14-cycle gap is tolerated and the frame completes.
    send_bits(8'h96, 0, 3, 1'b1);
    for (int g = 0; g < 14; g++) step(1'b0, 1'b1, 1'b1);
    checks++;
    if (status() !== 6'b001100) begin
      errors++;
      $display("FAIL gap14_hold: status=%b, expected status=%b", status(), 6'b001100);
    end
    send_bits(8'h96, 4, 7, 1'b0);
    checks++;
    if ({status(), y_out} !== {6'b101000, 8'h96}) begin
      errors++;
      $display("FAIL gap14_done: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b101000, 8'h96);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(8'hFF, 0, 5, 1'b1);
    rst_in = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst_in = 1'b0;
    checks++;
    if ({status(), y_out} !== {6'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid: status=%b y=%h, expected status=%b y=%h",
               status(), y_out, 6'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({status(), y_out} !== {6'b0, 8'h00}) begin
        errors++;
        $display("FAIL rst_mid_after[%0d]: status=%b y=%h, expected status=%b y=%h",
                 i, status(), y_out, 6'b0, 8'h00);
      end
    end
  endtask

  initial begin
    rst_in  = 1'b1;
    d_in    = 1'b0;
    vld_in  = 1'b0;
    sync_in = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_idle_ignore();
    test_framing_error();
    test_gap();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
